// File: rtl/z80_seq_pkg.sv
// Shared types and constants for the Z80 opcode-fetch sequencer.
package z80_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_T1,
    S_T2,
    S_TW,
    S_T3,
    S_T4
  } state_e;

  localparam logic [7:0] PFX_CB = 8'hCB;
  localparam logic [7:0] PFX_ED = 8'hED;
  localparam logic [7:0] PFX_DD = 8'hDD;
  localparam logic [7:0] PFX_FD = 8'hFD;

  localparam int TCNT_W = 8;

  typedef struct packed {
    logic m1_n;
    logic mreq_n;
    logic rd_n;
    logic rfsh_n;
  } strobes_t;

  // Bus strobe pattern driven while the M1 cycle sits in a given T-state.
  function automatic strobes_t strobes_for(state_e s);
    strobes_t st;
    st = '1;
    case (s)
      S_T1, S_T2, S_TW: begin
        st.m1_n   = 1'b0;
        st.mreq_n = 1'b0;
        st.rd_n   = 1'b0;
      end
      S_T3: begin
        st.mreq_n = 1'b0;
        st.rfsh_n = 1'b0;
      end
      S_T4: begin
        st.rfsh_n = 1'b0;
      end
      default: st = '1;
    endcase
    return st;
  endfunction

  function automatic logic is_prefix(logic [7:0] b);
    return (b == PFX_CB) || (b == PFX_ED) || (b == PFX_DD) || (b == PFX_FD);
  endfunction

endpackage

// File: rtl/z80_m1_cycle.sv
// One M1 machine cycle: T-state sequencing, wait handling, registered
// strobes and the opcode byte latch.
module z80_m1_cycle
  import z80_seq_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       go_i,
  input  logic       wait_ni,
  input  logic [7:0] data_i,
  output state_e     state_o,
  output strobes_t   strb_o,
  output logic [7:0] byte_o
);

  state_e     state_q, state_d;
  strobes_t   strb_q;
  logic [7:0] byte_q;

  // Next T-state: waits stretch T2 via TW, T4 either chains or goes idle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (go_i) state_d = S_T1;
      S_T1:       state_d = S_T2;
      S_T2, S_TW: state_d = wait_ni ? S_T3 : S_TW;
      S_T3:       state_d = S_T4;
      S_T4:       state_d = go_i ? S_T1 : S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // State, strobes registered from the next state, byte captured on the last wait-sampled cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      strb_q  <= '1;
      byte_q  <= '0;
    end else begin
      state_q <= state_d;
      strb_q  <= strobes_for(state_d);
      if ((state_q == S_T2 || state_q == S_TW) && wait_ni) begin
        byte_q <= data_i;
      end
    end
  end

  assign state_o = state_q;
  assign strb_o  = strb_q;
  assign byte_o  = byte_q;

endmodule

// File: rtl/z80_m1_sequencer.sv
// Opcode fetch controller: chains M1 cycles across CB/ED/DD/FD prefixes
// and retires the collected opcode bytes with byte/M1/T-state counts.
module z80_m1_sequencer
  import z80_seq_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [15:0] ip,
  input  logic [15:0] ir,
  input  logic        wait_n,
  input  logic [7:0]  data_in,
  output logic [15:0] addr,
  output logic        m1_n,
  output logic        mreq_n,
  output logic        rd_n,
  output logic        rfsh_n,
  output logic        busy,
  output logic        r_inc,
  output logic        insn_valid,
  output logic [15:0] insn,
  output logic [1:0]  insn_len,
  output logic [2:0]  m1_count,
  output logic        indexed_cb,
  output logic [7:0]  tcycles
);

  state_e      cyc_state;
  strobes_t    cyc_strb;
  logic [7:0]  cur_byte;

  logic              pfx_q;
  logic [7:0]        buf0_q;
  logic [15:0]       insn_q;
  logic [1:0]        len_q;
  logic [2:0]        m1_count_q;
  logic              idx_q;
  logic [TCNT_W-1:0] tcycles_q;
  logic              insn_valid_q;

  logic accept, is_t4, chain, two_byte, idx_d, go;

  assign accept = (cyc_state == S_IDLE) && start;
  assign is_t4  = (cyc_state == S_T4);
  assign busy   = (cyc_state != S_IDLE);
  assign go     = accept || (is_t4 && chain);

  z80_m1_cycle u_cycle (
    .clk_i   (clk),
    .rst_ni  (reset_n),
    .go_i    (go),
    .wait_ni (wait_n),
    .data_i  (data_in),
    .state_o (cyc_state),
    .strb_o  (cyc_strb),
    .byte_o  (cur_byte)
  );

  // End-of-T4 decision on the latched byte given the currently held prefix.
  always_comb begin
    chain    = 1'b0;
    two_byte = 1'b0;
    idx_d    = 1'b0;
    if (!pfx_q) begin
      chain = is_prefix(cur_byte);
    end else if (buf0_q == PFX_CB || buf0_q == PFX_ED) begin
      two_byte = 1'b1;
    end else if (cur_byte == PFX_CB) begin
      two_byte = 1'b1;
      idx_d    = 1'b1;
    end else if (cur_byte == PFX_DD || cur_byte == PFX_FD || cur_byte == PFX_ED) begin
      chain = 1'b1;
    end else begin
      two_byte = 1'b1;
    end
  end

  // Fetch address during the read phase, refresh address during T3/T4.
  always_comb begin
    case (cyc_state)
      S_T1, S_T2, S_TW: addr = ip + {13'b0, m1_count_q};
      S_T3, S_T4:       addr = ir;
      default:          addr = 16'h0000;
    endcase
  end

  // Prefix buffer, counters and retirement registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pfx_q        <= 1'b0;
      buf0_q       <= '0;
      insn_q       <= '0;
      len_q        <= '0;
      m1_count_q   <= '0;
      idx_q        <= 1'b0;
      tcycles_q    <= '0;
      insn_valid_q <= 1'b0;
    end else begin
      insn_valid_q <= is_t4 && !chain;
      if (accept) begin
        pfx_q      <= 1'b0;
        buf0_q     <= '0;
        insn_q     <= '0;
        len_q      <= '0;
        m1_count_q <= '0;
        idx_q      <= 1'b0;
        tcycles_q  <= '0;
      end else if (busy) begin
        if (tcycles_q != '1) tcycles_q <= tcycles_q + 1'b1;
        if (is_t4) begin
          m1_count_q <= m1_count_q + 3'd1;
          if (chain) begin
            buf0_q <= cur_byte;
            pfx_q  <= 1'b1;
          end else begin
            insn_q <= two_byte ? {cur_byte, buf0_q} : {8'h00, cur_byte};
            len_q  <= two_byte ? 2'd2 : 2'd1;
            idx_q  <= idx_d;
          end
        end
      end
    end
  end

  assign m1_n       = cyc_strb.m1_n;
  assign mreq_n     = cyc_strb.mreq_n;
  assign rd_n       = cyc_strb.rd_n;
  assign rfsh_n     = cyc_strb.rfsh_n;
  assign r_inc      = is_t4;
  assign insn_valid = insn_valid_q;
  assign insn       = insn_q;
  assign insn_len   = len_q;
  assign m1_count   = m1_count_q;
  assign indexed_cb = idx_q;
  assign tcycles    = tcycles_q;

endmodule

// File: tb/tb_z80_m1_sequencer.sv
// Scoreboard bench for the M1 fetch sequencer: a per-cycle bus schedule
// drives data/wait and checks strobes, a monitor checks each retirement.
module tb_z80_m1_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [15:0] ip, ir;
  logic        wait_n;
  logic [7:0]  data_in;
  logic [15:0] addr;
  logic        m1_n, mreq_n, rd_n, rfsh_n;
  logic        busy, r_inc, insn_valid;
  logic [15:0] insn;
  logic [1:0]  insn_len;
  logic [2:0]  m1_count;
  logic        indexed_cb;
  logic [7:0]  tcycles;

  z80_m1_sequencer dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .ip         (ip),
    .ir         (ir),
    .wait_n     (wait_n),
    .data_in    (data_in),
    .addr       (addr),
    .m1_n       (m1_n),
    .mreq_n     (mreq_n),
    .rd_n       (rd_n),
    .rfsh_n     (rfsh_n),
    .busy       (busy),
    .r_inc      (r_inc),
    .insn_valid (insn_valid),
    .insn       (insn),
    .insn_len   (insn_len),
    .m1_count   (m1_count),
    .indexed_cb (indexed_cb),
    .tcycles    (tcycles)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int cmpCount = 0;
  int errCount = 0;

  typedef struct {
    logic [15:0] insn;
    logic [1:0]  len;
    logic [2:0]  m1;
    logic        idx;
    logic [7:0]  tc;
    int          due;
  } exp_t;

  exp_t sb[$];

  // Fetch plan: bytes offered on successive M1 cycles and their wait counts.
  logic [7:0]  pb[5];
  int          pw[5];
  logic [15:0] expInsn;
  logic [1:0]  expLen;
  logic        expIdx;
  int          expM1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    cmpCount++;
    if (act !== req) begin
      errCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic isPfx(input logic [7:0] b);
    return b == 8'hCB || b == 8'hED || b == 8'hDD || b == 8'hFD;
  endfunction

  // Walk the planned bytes through the prefix rules to find the instruction.
  task automatic modelInsn();
    logic       held;
    logic [7:0] p;
    logic       done;
    held = 1'b0; p = 8'h00; done = 1'b0;
    expIdx = 1'b0; expM1 = 0; expInsn = 16'h0; expLen = 2'd0;
    for (int k = 0; k < 5 && !done; k++) begin
      expM1 = k + 1;
      if (!held) begin
        if (isPfx(pb[k])) begin held = 1'b1; p = pb[k]; end
        else begin expInsn = {8'h00, pb[k]}; expLen = 2'd1; done = 1'b1; end
      end else if (p == 8'hCB || p == 8'hED) begin
        expInsn = {pb[k], p}; expLen = 2'd2; done = 1'b1;
      end else if (pb[k] == 8'hCB) begin
        expInsn = {pb[k], p}; expLen = 2'd2; expIdx = 1'b1; done = 1'b1;
      end else if (pb[k] == 8'hDD || pb[k] == 8'hFD || pb[k] == 8'hED) begin
        p = pb[k];
      end else begin
        expInsn = {pb[k], p}; expLen = 2'd2; done = 1'b1;
      end
    end
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
    checkOutput({tag, "_strobes"}, 32'({m1_n, mreq_n, rd_n, rfsh_n}), 32'hF);
    checkOutput({tag, "_addr"}, 32'(addr), 32'd0);
  endtask

  // Issue one fetch at the current (idle) negedge and run its full bus schedule.
  task automatic applyStimulus(input logic [15:0] ipv, input logic [15:0] irv);
    int   role[$];
    int   mk[$];
    logic fin[$];
    exp_t e;
    logic [15:0] a;
    modelInsn();
    for (int k = 0; k < expM1; k++) begin
      role.push_back(0); mk.push_back(k); fin.push_back(1'b0);
      role.push_back(1); mk.push_back(k); fin.push_back(pw[k] == 0);
      for (int i = 1; i <= pw[k]; i++) begin
        role.push_back(2); mk.push_back(k); fin.push_back(i == pw[k]);
      end
      role.push_back(3); mk.push_back(k); fin.push_back(1'b0);
      role.push_back(4); mk.push_back(k); fin.push_back(1'b0);
    end
    ip = ipv; ir = irv; start = 1'b1; wait_n = 1'b1; data_in = 8'($urandom);
    e.insn = expInsn; e.len = expLen; e.m1 = 3'(expM1); e.idx = expIdx;
    e.tc = 8'(role.size()); e.due = cyc + role.size() + 1;
    sb.push_back(e);
    for (int j = 0; j < role.size(); j++) begin
      @(negedge clk);
      start = 1'($urandom_range(1, 0));
      checkOutput("busy", 32'(busy), 32'd1);
      a = ipv + 16'(mk[j]);
      case (role[j])
        0, 1, 2: begin
          checkOutput("fetch_strobes", 32'({m1_n, mreq_n, rd_n, rfsh_n}), 32'b0001);
          checkOutput("fetch_addr", 32'(addr), 32'(a));
        end
        3: begin
          checkOutput("t3_strobes", 32'({m1_n, mreq_n, rd_n, rfsh_n}), 32'b1010);
          checkOutput("t3_addr", 32'(addr), 32'(irv));
        end
        default: begin
          checkOutput("t4_strobes", 32'({m1_n, mreq_n, rd_n, rfsh_n}), 32'b1110);
          checkOutput("t4_addr", 32'(addr), 32'(irv));
        end
      endcase
      if (role[j] == 1 || role[j] == 2) wait_n = fin[j];
      else wait_n = 1'($urandom_range(1, 0));
      data_in = fin[j] ? pb[mk[j]] : 8'($urandom);
    end
    @(negedge clk);
    start = 1'b0; wait_n = 1'b1;
    checkIdle("retire");
  endtask

  // Monitor: pop the expected record whenever the DUT retires.
  int rincCount = 0;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        rincCount = 0;
      end else begin
        if (r_inc) rincCount++;
        if (insn_valid) begin
          if (sb.size() == 0) begin
            cmpCount++; errCount++;
            $display("[TB] FAIL unexpected_valid: got insn %0h, expected no retirement", insn);
          end else begin
            e = sb.pop_front();
            checkOutput("valid_cycle", 32'(cyc), 32'(e.due));
            checkOutput("insn", 32'(insn), 32'(e.insn));
            checkOutput("insn_len", 32'(insn_len), 32'(e.len));
            checkOutput("m1_count", 32'(m1_count), 32'(e.m1));
            checkOutput("indexed_cb", 32'(indexed_cb), 32'(e.idx));
            checkOutput("tcycles", 32'(tcycles), 32'(e.tc));
            checkOutput("r_inc_pulses", 32'(rincCount), 32'(e.m1));
          end
          rincCount = 0;
        end else if (sb.size() > 0 && cyc > sb[0].due) begin
          e = sb.pop_front();
          cmpCount++; errCount++;
          $display("[TB] FAIL retire_timeout: got no insn_valid by cycle %0d, expected at %0d", cyc, e.due);
          rincCount = 0;
        end
      end
    end
  end

  initial begin
    int gap;
    reset_n = 1'b0; start = 1'b0; wait_n = 1'b1; data_in = 8'h00;
    ip = 16'h0000; ir = 16'h0000;
    repeat (3) @(negedge clk);
    checkIdle("reset");
    checkOutput("reset_insn", 32'(insn), 32'd0);
    checkOutput("reset_tcycles", 32'(tcycles), 32'd0);
    checkOutput("reset_valid", 32'(insn_valid), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    $display("[TB] directed fetches");
    pb = '{8'h2F, 8'h00, 8'h00, 8'h00, 8'h00}; pw = '{0, 0, 0, 0, 0};
    applyStimulus(16'h1000, 16'h3A55);
    pb = '{8'hED, 8'h44, 8'h00, 8'h00, 8'h00}; pw = '{0, 0, 0, 0, 0};
    applyStimulus(16'hFFFF, 16'h1234);
    pb = '{8'h2F, 8'h00, 8'h00, 8'h00, 8'h00}; pw = '{2, 0, 0, 0, 0};
    applyStimulus(16'h0100, 16'h0101);
    pb = '{8'hDD, 8'hFD, 8'h21, 8'h00, 8'h00}; pw = '{0, 0, 0, 0, 0};
    applyStimulus(16'h2000, 16'h7F00);
    pb = '{8'hDD, 8'hCB, 8'h05, 8'h06, 8'h00}; pw = '{0, 1, 0, 0, 0};
    applyStimulus(16'h4000, 16'h0203);
    @(negedge clk);

    $display("[TB] reset during fetch");
    ip = 16'h3000; ir = 16'h0909; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    checkIdle("midreset");
    checkOutput("midreset_valid", 32'(insn_valid), 32'd0);
    checkOutput("midreset_insn", 32'(insn), 32'd0);
    checkOutput("midreset_tcycles", 32'(tcycles), 32'd0);
    checkOutput("midreset_m1_count", 32'(m1_count), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    pb = '{8'hED, 8'h44, 8'h00, 8'h00, 8'h00}; pw = '{0, 0, 0, 0, 0};
    applyStimulus(16'h3000, 16'h0909);

    $display("[TB] random fetches");
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < 5; i++) begin
        if (i < 4 && $urandom_range(1, 0) == 1) begin
          case ($urandom_range(3, 0))
            0: pb[i] = 8'hCB;
            1: pb[i] = 8'hED;
            2: pb[i] = 8'hDD;
            default: pb[i] = 8'hFD;
          endcase
        end else begin
          pb[i] = 8'($urandom);
          while (i == 4 && isPfx(pb[i])) pb[i] = 8'($urandom);
        end
        pw[i] = $urandom_range(2, 0);
      end
      applyStimulus(16'($urandom), 16'($urandom));
      gap = $urandom_range(2, 0);
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        checkIdle("gap");
      end
    end

    repeat (3) @(negedge clk);
    if (sb.size() != 0) begin
      cmpCount++; errCount++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, errCount);
    $finish;
  end

endmodule
